instr_fetch_queue: RTL

//  Upstream feeder for the ALU/register-file core. Assembles 16-bit instructions from a byte stream
//  (low byte first) and buffers them in a DEPTH-entry FIFO. Issues them to the core over a

---
 rtl/instr_fetch_queue_pkg.sv | 49 ++++
 rtl/instr_fetch_queue_if.sv | 30 +++
 rtl/instr_fetch_queue_fetch_fifo.sv | 69 ++++++
 rtl/instr_fetch_queue.sv | 102 ++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared instruction-format definitions for the fetch queue and the core's decoder.
package instr_fetch_queue_pkg;

  localparam int INST_W = 16;

  localparam logic [2:0] OP_REGWRITE = 3'b011;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 3;
  localparam int FUNC_LSB   = 3;
  localparam int FUNC_W     = 4;
  localparam int REG2_LSB   = 7;
  localparam int REG2_W     = 3;
  localparam int REG1_LSB   = 10;
  localparam int REG1_W     = 3;
  localparam int REGW_LSB   = 13;
  localparam int REGW_W     = 3;

  typedef logic [REGW_W-1:0] reg_idx_t;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  typedef struct packed {
    reg_idx_t          regw;
    reg_idx_t          reg1;
    reg_idx_t          reg2;
    logic [FUNC_W-1:0] func;
    logic [OPCODE_W-1:0] opcode;
  } inst_fields_t;

  function automatic inst_fields_t decode(input logic [INST_W-1:0] inst);
    inst_fields_t f;
    f.opcode = inst[OPCODE_LSB +: OPCODE_W];
    f.func   = inst[FUNC_LSB   +: FUNC_W];
    f.reg2   = inst[REG2_LSB   +: REG2_W];
    f.reg1   = inst[REG1_LSB   +: REG1_W];
    f.regw   = inst[REGW_LSB   +: REGW_W];
    return f;
  endfunction

  // Register writes land on a pair {w, w+1}; the +1 wraps 7 -> 0.
  function automatic logic pair_hit(input reg_idx_t r, input reg_idx_t w);
    return (r == w) || (r == reg_idx_t'(w + reg_idx_t'(1)));
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Byte-stream input, instruction-issue handshake and status of the fetch queue.
interface instr_fetch_queue_if
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic              flush;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid;
  logic              inst_ready;
  logic              stall;
  logic [LW-1:0]     fifo_level;
  logic [7:0]        issue_cnt;

  modport master (
    output flush, byte_in, byte_valid, inst_ready,
    input  byte_ready, inst_out, inst_valid, stall, fifo_level, issue_cnt
  );

  modport slave (
    input  flush, byte_in, byte_valid, inst_ready,
    output byte_ready, inst_out, inst_valid, stall, fifo_level, issue_cnt
  );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Show-ahead instruction FIFO with level count; a pop never frees room for a same-cycle push.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [INST_W-1:0] wdata,
  input  logic              pop,
  output logic [INST_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale words are never visible because level gates them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Byte assembler, register-pair hazard hold and issue counter in front of the fetch FIFO.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int HAZ_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_queue_if.slave bus
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int HW = (HAZ_CYCLES < 1) ? 1 : $clog2(HAZ_CYCLES + 1);

  phase_e            phase_q, phase_d;
  logic [7:0]        lo_q, lo_d;
  logic [HW-1:0]     hold_q, hold_d;
  reg_idx_t          last_w_q, last_w_d;
  logic [7:0]        issue_cnt_q, issue_cnt_d;

  logic [INST_W-1:0] head;
  inst_fields_t      head_f;
  logic              full, empty;
  logic [LW-1:0]     level;
  logic              conflict, byte_ready, byte_fire, push, inst_valid, stall, issue;

  fetch_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush),
    .push  (push),
    .wdata ({bus.byte_in, lo_q}),
    .pop   (issue),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    head_f   = decode(head);
    conflict = (hold_q != '0) &
               (pair_hit(head_f.reg1, last_w_q) | pair_hit(head_f.reg2, last_w_q));
    // A byte offered during flush is consumed and dropped, so ready stays high then.
    byte_ready = bus.flush | (phase_q == PH_LO) | ~full;
    byte_fire  = bus.byte_valid & byte_ready & ~bus.flush;
    push       = byte_fire & (phase_q == PH_HI);
    inst_valid = ~empty & ~conflict & ~bus.flush;
    stall      = ~empty & conflict;
    issue      = inst_valid & bus.inst_ready;

    phase_d     = phase_q;
    lo_d        = lo_q;
    hold_d      = (hold_q == '0) ? '0 : hold_q - HW'(1);
    last_w_d    = last_w_q;
    issue_cnt_d = issue_cnt_q + 8'(issue);

    if (bus.flush) begin
      phase_d = PH_LO;
      lo_d    = '0;
      hold_d  = '0;
    end else begin
      if (byte_fire) begin
        if (phase_q == PH_LO) begin
          lo_d    = bus.byte_in;
          phase_d = PH_HI;
        end else begin
          phase_d = PH_LO;
        end
      end
      if (issue && head_f.opcode == OP_REGWRITE) begin
        hold_d   = HW'(HAZ_CYCLES);
        last_w_d = head_f.regw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_LO;
      lo_q        <= '0;
      hold_q      <= '0;
      last_w_q    <= '0;
      issue_cnt_q <= '0;
    end else begin
      phase_q     <= phase_d;
      lo_q        <= lo_d;
      hold_q      <= hold_d;
      last_w_q    <= last_w_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_out   = inst_valid ? head : '0;
  assign bus.stall      = stall;
  assign bus.fifo_level = level;
  assign bus.issue_cnt  = issue_cnt_q;

endmodule
